ttt_tick_sequencer: RTL
=======================

// Module: ttt_tick_sequencer
// PURPOSE
//  Upstream host-side driver for the tick-tock-tokens processor wrapper; drives its ui_in[3:0]/uio_in.
//  Buffers incoming good/bad token events in a FIFO. On each tick it issues one add instruction per
//  buffered event, then tally (4'b1000), then countdown (4'b1001).
//  Samples the returned start/stop flags and presents them as one-cycle pulses to downstream logic.
// PARAMETERS
//  FIFO_DEPTH  8  token-event FIFO entries; must be a power of 2, >=2
//  RESP_LAT    1  cycles from instruction presented to valid proc_result (wrapper registers expect_data)
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  reset, synchronous, active-low
//  tick         in   1  time-step strobe, 1-cycle pulse
//  ev_valid     in   1  token event valid
//  ev_ready     out  1  token event accepted when valid&ready
//  ev_data      in   8  {gb, count[6:0]}: gb=0 good, gb=1 bad
//  proc_instr   out  4  to processor ui_in[3:0]
//  proc_data    out  8  to processor uio_in
//  proc_result  in   8  from processor uo_out
//  token_start  out  1  1-cycle pulse: processor reported start (result bit1 after tally)
//  token_stop   out  1  1-cycle pulse: processor reported stop (result bit0 after tally or countdown)
//  busy         out  1  sequencer not in IDLE
//  overrun      out  1  sticky: tick arrived while one tick was already pending
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0 except proc_instr=4'b0011 (read-only idle op). FIFO emptied, pending tick
//   cleared, overrun cleared, state=IDLE. Reset asserted mid-sequence aborts immediately.
//  FIFO: ev_ready = !full, no bypass. A push at full is ignored. Push and pop may occur in the same
//   cycle; occupancy is then unchanged.
//  Tick capture: tick with pend=0 sets pend.
//   - tick while pend=1 sets overrun; the tick is otherwise dropped.
//   - tick in the same cycle IDLE consumes pend keeps pend=1.
//  States: IDLE -> DRAIN -> TALLY -> T_WAIT -> COUNT -> C_WAIT -> IDLE.
//  IDLE:
//   - proc_instr=4'b0011, proc_data=0.
//   - If pend: clear pend; latch snap=fifo_count; go to DRAIN (or to TALLY if snap=0).
//  DRAIN:
//   - Each cycle pop one entry: proc_instr={3'b000,gb}, proc_data={gb,count}; decrement snap.
//   - Go to TALLY after the last snapped entry.
//   - Events pushed during DRAIN wait for the next tick.
//  TALLY: one cycle, proc_instr=4'b1000, proc_data=0.
//  T_WAIT:
//   - proc_instr=4'b0011 for RESP_LAT cycles.
//   - On the final cycle sample proc_result[1:0]; pulse token_start=bit1 and token_stop=bit0 on the next cycle.
//  COUNT: one cycle, proc_instr=4'b1001.
//  C_WAIT:
//   - Same as T_WAIT, but only token_stop is pulsed from bit0; token_start is not driven from countdown.
//   - Then go to IDLE.
//  Latency: tick in IDLE with N snapped events -> token_start/stop pulse at cycle 1+N+1+RESP_LAT+1.
//  proc_instr/proc_data are registered outputs; they change only on clk edges.
//  token_start and token_stop are never high for more than one cycle.
//  token_stop may pulse twice per tick, once from tally and once from countdown.
// CONFIGURATION
//  TTT_SEQ_STATS_EN defined:
//   - Adds outputs start_total[15:0], stop_total[15:0], ev_total[15:0].
//   - Each increments on token_start pulse, token_stop pulse, and FIFO push respectively.
//   - Saturating at 16'hFFFF; cleared by reset.
//  TTT_SEQ_STATS_EN undefined: those ports and counters are absent; all other behaviour identical.
// TESTING
//  1. Reset:
//     - Hold rst_n=0 mid-DRAIN with 3 entries queued -> next cycle busy=0, fifo_count=0,
//       proc_instr=4'b0011, overrun=0.
//  2. Basic tick:
//     - Push {0,7'd5}, {1,7'd2}, then tick -> proc_instr sequence 0000/0x05, 0001/0x82, 1000,
//       0011 (RESP_LAT=1), 1001, 0011.
//     - Then IDLE.
//  3. Flag return:
//     - Model returns 8'h02 after tally and 8'h01 after countdown -> one token_start pulse,
//       then one token_stop pulse.
//     - Check pulse cycles against the latency formula.
//  4. FIFO full:
//     - Push 9 events with FIFO_DEPTH=8 and no tick -> ev_ready=0 after the 8th; the 9th is not accepted.
//     - Tick -> exactly 8 add instructions issued.
//  5. Tick overrun:
//     - Tick during DRAIN -> pend set, second sequence runs after C_WAIT.
//     - Two more ticks before IDLE -> overrun=1 and stays 1.
//  6. Stats (TTT_SEQ_STATS_EN):
//     - After tests 2 and 3 -> ev_total=2, start_total=1, stop_total=1.
//     - Rerun without the macro and confirm identical proc_instr traces.

Source files
------------

// File: rtl/ttt_tick_sequencer.sv
// ttt_tick_sequencer
//   Host-side driver for the tick-tock-tokens processor wrapper. Token events (good/bad add
//   requests) are queued in a FIFO. Each time-step tick replays the queued events as add
//   instructions, then issues tally and countdown. The start/stop flags returned for those
//   two instructions come out as one-cycle pulses.
//
// Parameters
//   FIFO_DEPTH  token-event FIFO entries (power of 2, >= 2)
//   RESP_LAT    cycles from instruction presented to valid proc_result (>= 1)
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   tick                  time-step strobe (1-cycle pulse)
//   ev_valid/ev_ready     token event handshake; ev_data = {gb, count[6:0]}, gb=1 means bad
//   proc_instr/proc_data  instruction/operand to processor ui_in[3:0]/uio_in (registered)
//   proc_result           processor uo_out
//   token_start/stop      one-cycle flag pulses (start from tally, stop from tally or countdown)
//   busy                  sequence in progress
//   overrun               sticky: tick arrived while a tick was already pending
//   fifo_count            FIFO occupancy
//
// Optional feature, enabled by defining TTT_SEQ_STATS_EN:
//   start_total/stop_total/ev_total saturating 16-bit counters of start pulses, stop pulses
//   and accepted FIFO pushes.

module ttt_tick_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RESP_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [7:0]                  ev_data,
    output logic [3:0]                  proc_instr,
    output logic [7:0]                  proc_data,
    input  logic [7:0]                  proc_result,
    output logic                        token_start,
    output logic                        token_stop,
    output logic                        busy,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef TTT_SEQ_STATS_EN
    ,
    output logic [15:0]                 start_total,
    output logic [15:0]                 stop_total,
    output logic [15:0]                 ev_total
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned WW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [AW:0]   DepthVal = (AW + 1)'(FIFO_DEPTH);
    localparam logic [WW-1:0] WaitInit = WW'(RESP_LAT - 1);

    localparam logic [3:0] InstrIdle  = 4'b0011;
    localparam logic [3:0] InstrTally = 4'b1000;
    localparam logic [3:0] InstrCount = 4'b1001;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StTally,
        StTWait,
        StCount,
        StCWait
    } state_t;

    state_t        state_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   remain_q;   // snapped entries still to pop after the current one
    logic [WW-1:0] wait_q;
    logic          pend_q;
    logic          full, push, pop, consume;
    logic [7:0]    head;
    logic          unused_result;

    assign unused_result = ^proc_result[7:2];

    assign full       = (count_q == DepthVal);
    assign ev_ready   = !full;
    assign push       = ev_valid && !full;
    assign head       = mem[rd_ptr_q];
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle);
    assign consume    = (state_q == StIdle) && pend_q;
    // Pops happen on the edge that registers each add instruction.
    assign pop        = (consume && count_q != '0) || (state_q == StDrain && remain_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ev_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // A tick coinciding with IDLE consuming the pending tick becomes the new pending tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            overrun <= 1'b0;
        end else if (tick) begin
            if (pend_q && !consume) overrun <= 1'b1;
            else                    pend_q  <= 1'b1;
        end else if (consume) begin
            pend_q <= 1'b0;
        end
    end

    // Outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            proc_instr  <= InstrIdle;
            proc_data   <= '0;
            token_start <= 1'b0;
            token_stop  <= 1'b0;
            remain_q    <= '0;
            wait_q      <= '0;
        end else begin
            token_start <= 1'b0;
            token_stop  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        if (count_q != '0) begin
                            proc_instr <= {3'b000, head[7]};
                            proc_data  <= head;
                            remain_q   <= count_q - 1'b1;
                            state_q    <= StDrain;
                        end else begin
                            proc_instr <= InstrTally;
                            proc_data  <= '0;
                            state_q    <= StTally;
                        end
                    end
                end
                StDrain: begin
                    if (remain_q != '0) begin
                        proc_instr <= {3'b000, head[7]};
                        proc_data  <= head;
                        remain_q   <= remain_q - 1'b1;
                    end else begin
                        proc_instr <= InstrTally;
                        proc_data  <= '0;
                        state_q    <= StTally;
                    end
                end
                StTally: begin
                    proc_instr <= InstrIdle;
                    wait_q     <= WaitInit;
                    state_q    <= StTWait;
                end
                StTWait: begin
                    if (wait_q == '0) begin
                        token_start <= proc_result[1];
                        token_stop  <= proc_result[0];
                        proc_instr  <= InstrCount;
                        state_q     <= StCount;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StCount: begin
                    proc_instr <= InstrIdle;
                    wait_q     <= WaitInit;
                    state_q    <= StCWait;
                end
                StCWait: begin
                    if (wait_q == '0) begin
                        token_stop <= proc_result[0];
                        state_q    <= StIdle;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                default: begin
                    proc_instr <= InstrIdle;
                    proc_data  <= '0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

`ifdef TTT_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_total <= '0;
            stop_total  <= '0;
            ev_total    <= '0;
        end else begin
            if (token_start && start_total != 16'hFFFF) start_total <= start_total + 16'd1;
            if (token_stop && stop_total != 16'hFFFF)   stop_total  <= stop_total + 16'd1;
            if (push && ev_total != 16'hFFFF)           ev_total    <= ev_total + 16'd1;
        end
    end
`endif

endmodule
